// File: rtl/ex_mem_stage_pkg.sv
// Purpose : shared EX/MEM control-bundle layout, reused by the neighbouring pipeline stages.
// Latency : n/a (types and helpers only).
// Backpressure: n/a.
//
// ctrl_t bit order (MSB..LSB): reg_write, mem_read, mem_write, mem_to_reg, branch.
// Inside the EX/MEM register the branch bit holds the resolved "taken" decision,
// not the raw branch request.
package ex_mem_stage_pkg;

  localparam int CTRL_W = 5;

  typedef struct packed {
    logic reg_write;
    logic mem_read;
    logic mem_write;
    logic mem_to_reg;
    logic branch;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  // Branch is taken only for a real instruction that requested a branch and saw Zero.
  function automatic logic branch_resolve(input logic valid, input ctrl_t ctrl,
                                          input logic zero);
    return valid & ctrl.branch & zero;
  endfunction

endpackage

// File: rtl/ex_mem_stage_sat_counter.sv
// Purpose : saturating up-counter for EX/MEM performance statistics.
// Latency : count visible one cycle after inc_i.
// Backpressure: none; sticks at all-ones.
//
// Ports: clk_i, rst_i (async active-low), inc_i (count enable), cnt_o (current count).
// Only compiled when EX_MEM_PERF_CNT_EN is defined, the only build that uses it.
`ifdef EX_MEM_PERF_CNT_EN
module ex_mem_stage_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      cnt_o <= '0;
    end else if (inc_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/ex_mem_stage.sv
// Purpose : EX/MEM pipeline register with stall/flush, branch redirect and forwarding info.
// Latency : 1 cycle input->output; branch_taken_o pulses once per captured taken branch.
// Backpressure: stall_i holds the entry; flush_i (wins over stall_i) writes a bubble.
//
// Ports: clk_i, rst_i (async active-low), stall_i, flush_i, valid_i, alu_data_i, zero_i,
//   rt_data_i, rd_addr_i, control bits *_i, branch_target_i -> registered valid_o, data,
//   rd_addr_o, control bits *_o (gated by valid), branch_taken_o, branch_target_o, fwd_en_o.
// Optional EX_MEM_PERF_CNT_EN: adds CNT_W and bubble_cnt_o / stall_cnt_o saturating counters.
module ex_mem_stage
  import ex_mem_stage_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
`ifdef EX_MEM_PERF_CNT_EN
  , parameter int CNT_W    = 16
`endif
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [DATA_W-1:0]     alu_data_i,
  input  logic                  zero_i,
  input  logic [DATA_W-1:0]     rt_data_i,
  input  logic [REG_ADDR_W-1:0] rd_addr_i,
  input  logic                  reg_write_i,
  input  logic                  mem_read_i,
  input  logic                  mem_write_i,
  input  logic                  mem_to_reg_i,
  input  logic                  branch_i,
  input  logic [DATA_W-1:0]     branch_target_i,
  output logic                  valid_o,
  output logic [DATA_W-1:0]     alu_data_o,
  output logic [DATA_W-1:0]     rt_data_o,
  output logic [REG_ADDR_W-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  mem_read_o,
  output logic                  mem_write_o,
  output logic                  mem_to_reg_o,
  output logic                  branch_taken_o,
  output logic [DATA_W-1:0]     branch_target_o,
  output logic                  fwd_en_o
`ifdef EX_MEM_PERF_CNT_EN
  , output logic [CNT_W-1:0]    bubble_cnt_o
  , output logic [CNT_W-1:0]    stall_cnt_o
`endif
);

  ctrl_t                 w_ctrl_in;
  logic                  w_load_bubble;

  logic                  r_valid;
  ctrl_t                 r_ctrl;        // r_ctrl.branch = resolved taken decision
  logic                  r_redirect_done;
  logic [DATA_W-1:0]     r_alu;
  logic [DATA_W-1:0]     r_rt;
  logic [REG_ADDR_W-1:0] r_rd;
  logic [DATA_W-1:0]     r_target;

  assign w_ctrl_in = {reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i};

  // A bubble is written on flush (even under stall) or on a load of a non-instruction.
  assign w_load_bubble = flush_i | (~stall_i & ~valid_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_valid         <= 1'b0;
      r_ctrl          <= CTRL_NOP;
      r_redirect_done <= 1'b0;
      r_alu           <= '0;
      r_rt            <= '0;
      r_rd            <= '0;
      r_target        <= '0;
    end else if (w_load_bubble) begin
      r_valid         <= 1'b0;
      r_ctrl          <= CTRL_NOP;
      r_redirect_done <= 1'b0;
      r_alu           <= '0;
      r_rt            <= '0;
      r_rd            <= '0;
      r_target        <= '0;
    end else if (stall_i) begin
      // Entry held: the redirect (if any) has already been seen for one cycle.
      r_redirect_done <= 1'b1;
    end else begin
      r_valid         <= 1'b1;
      r_ctrl          <= w_ctrl_in;
      r_ctrl.branch   <= branch_resolve(valid_i, w_ctrl_in, zero_i);
      r_redirect_done <= 1'b0;
      r_alu           <= alu_data_i;
      r_rt            <= rt_data_i;
      r_rd            <= rd_addr_i;
      r_target        <= branch_target_i;
    end
  end

  assign valid_o         = r_valid;
  assign alu_data_o      = r_alu;
  assign rt_data_o       = r_rt;
  assign rd_addr_o       = r_rd;
  assign branch_target_o = r_target;
  assign reg_write_o     = r_valid & r_ctrl.reg_write;
  assign mem_read_o      = r_valid & r_ctrl.mem_read;
  assign mem_write_o     = r_valid & r_ctrl.mem_write;
  assign mem_to_reg_o    = r_valid & r_ctrl.mem_to_reg;
  assign branch_taken_o  = r_valid & r_ctrl.branch & ~r_redirect_done;
  // r0 is hard-wired zero, so it is never a forwarding source.
  assign fwd_en_o        = r_valid & r_ctrl.reg_write & (r_rd != '0);

`ifdef EX_MEM_PERF_CNT_EN
  logic w_stall_edge;
  assign w_stall_edge = stall_i & ~flush_i;

  ex_mem_stage_sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_load_bubble),
    .cnt_o (bubble_cnt_o)
  );

  ex_mem_stage_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .inc_i (w_stall_edge),
    .cnt_o (stall_cnt_o)
  );
`endif

endmodule

// File: tb/tb_ex_mem_stage.sv
// Purpose : directed self-checking bench for ex_mem_stage.
// Latency : n/a.
// Backpressure: n/a.
module tb_ex_mem_stage;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;

  logic                  clk_i = 1'b0;
  logic                  rst_i;
  logic                  stall_i, flush_i, valid_i, zero_i;
  logic [DATA_W-1:0]     alu_data_i, rt_data_i, branch_target_i;
  logic [REG_ADDR_W-1:0] rd_addr_i;
  logic                  reg_write_i, mem_read_i, mem_write_i, mem_to_reg_i, branch_i;
  logic                  valid_o;
  logic [DATA_W-1:0]     alu_data_o, rt_data_o, branch_target_o;
  logic [REG_ADDR_W-1:0] rd_addr_o;
  logic                  reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o;
  logic                  branch_taken_o, fwd_en_o;
`ifdef EX_MEM_PERF_CNT_EN
  logic [1:0]            bubble_cnt_o, stall_cnt_o;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk_i = ~clk_i;

  ex_mem_stage #(
    .DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)
`ifdef EX_MEM_PERF_CNT_EN
    , .CNT_W(2)
`endif
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .alu_data_i(alu_data_i), .zero_i(zero_i), .rt_data_i(rt_data_i), .rd_addr_i(rd_addr_i),
    .reg_write_i(reg_write_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
    .mem_to_reg_i(mem_to_reg_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
    .valid_o(valid_o), .alu_data_o(alu_data_o), .rt_data_o(rt_data_o), .rd_addr_o(rd_addr_o),
    .reg_write_o(reg_write_o), .mem_read_o(mem_read_o), .mem_write_o(mem_write_o),
    .mem_to_reg_o(mem_to_reg_o), .branch_taken_o(branch_taken_o),
    .branch_target_o(branch_target_o), .fwd_en_o(fwd_en_o)
`ifdef EX_MEM_PERF_CNT_EN
    , .bubble_cnt_o(bubble_cnt_o), .stall_cnt_o(stall_cnt_o)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Packed snapshot of every control output: {valid, rw, mr, mw, m2r, taken, fwd}.
  function automatic logic [31:0] ctrl_vec();
    return {25'd0, valid_o, reg_write_o, mem_read_o, mem_write_o, mem_to_reg_o,
            branch_taken_o, fwd_en_o};
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    stall_i = 0; flush_i = 0; valid_i = 0; zero_i = 0;
    alu_data_i = '0; rt_data_i = '0; branch_target_i = '0; rd_addr_i = '0;
    reg_write_i = 0; mem_read_i = 0; mem_write_i = 0; mem_to_reg_i = 0; branch_i = 0;
  endtask

  initial begin
    idle_inputs();
    rst_i = 1'b0;
    #2;
    chk("reset_ctrl", ctrl_vec(), 32'h0);
    chk("reset_alu", alu_data_o, 32'h0);
    step();
    rst_i = 1'b1;

    // ALU add into r3, with store data
    valid_i = 1; alu_data_i = 32'h0000_0005; rd_addr_i = 5'd3; reg_write_i = 1;
    rt_data_i = 32'hCAFE_0001;
    step();
    chk("add_alu", alu_data_o, 32'h5);
    chk("add_rd", 32'(rd_addr_o), 32'd3);
    chk("add_rt", rt_data_o, 32'hCAFE_0001);
    chk("add_ctrl", ctrl_vec(), 32'b1100001);

    // Same write to r0: no forwarding
    rd_addr_i = 5'd0; alu_data_i = 32'h0000_0009;
    step();
    chk("r0_ctrl", ctrl_vec(), 32'b1100000);
    chk("r0_alu", alu_data_o, 32'h9);

    // Taken branch, then 3 stall cycles
    idle_inputs();
    valid_i = 1; branch_i = 1; zero_i = 1; branch_target_i = 32'h40;
    step();
    chk("br_taken", 32'(branch_taken_o), 32'd1);
    chk("br_tgt", branch_target_o, 32'h40);
    stall_i = 1; branch_target_i = 32'h99; valid_i = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("br_stall_taken", 32'(branch_taken_o), 32'd0);
      chk("br_stall_tgt", branch_target_o, 32'h40);
      chk("br_stall_valid", 32'(valid_o), 32'd1);
    end

    // Branch with Zero clear: never taken, even across a stall
    stall_i = 0; valid_i = 1; zero_i = 0; branch_target_i = 32'h80;
    step();
    chk("nbr_taken", 32'(branch_taken_o), 32'd0);
    chk("nbr_tgt", branch_target_o, 32'h80);
    stall_i = 1;
    step();
    chk("nbr_stall_taken", 32'(branch_taken_o), 32'd0);

    // Flush and stall together with a real instruction: bubble wins
    idle_inputs();
    valid_i = 1; reg_write_i = 1; mem_read_i = 1; rd_addr_i = 5'd7; alu_data_i = 32'h1234;
    flush_i = 1; stall_i = 1;
    step();
    chk("flush_ctrl", ctrl_vec(), 32'h0);
    chk("flush_alu", alu_data_o, 32'h0);
    chk("flush_rd", 32'(rd_addr_o), 32'd0);
    chk("flush_tgt", branch_target_o, 32'h0);

    // Store request on a non-instruction stays invisible
    idle_inputs();
    mem_write_i = 1; rt_data_i = 32'hDEAD_BEEF;
    step();
    chk("bub_mw", 32'(mem_write_o), 32'd0);
    chk("bub_rt", rt_data_o, 32'h0);

    // Real store/load control bits pass through
    valid_i = 1; mem_write_i = 1; mem_to_reg_i = 1; rd_addr_i = 5'd4;
    step();
    chk("st_ctrl", ctrl_vec(), 32'b1001100);
    chk("st_rt", rt_data_o, 32'hDEAD_BEEF);

    // Asynchronous reset between edges
    idle_inputs();
    valid_i = 1; reg_write_i = 1; rd_addr_i = 5'd9; alu_data_i = 32'h77;
    step();
    chk("pre_rst_ctrl", ctrl_vec(), 32'b1100001);
    #3;
    rst_i = 1'b0;
    #1;
    chk("arst_ctrl", ctrl_vec(), 32'h0);
    chk("arst_alu", alu_data_o, 32'h0);
    chk("arst_rd", 32'(rd_addr_o), 32'd0);
    step();
    chk("arst_hold", ctrl_vec(), 32'h0);

`ifdef EX_MEM_PERF_CNT_EN
    idle_inputs();
    valid_i = 1; stall_i = 1;
    rst_i = 1'b1;
    begin
      logic [1:0] exp_stall [5];
      exp_stall = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
      for (int i = 0; i < 5; i++) begin
        step();
        chk("stall_cnt", 32'(stall_cnt_o), 32'(exp_stall[i]));
      end
    end
    chk("bubble_cnt_0", 32'(bubble_cnt_o), 32'd0);
    stall_i = 0; flush_i = 1;
    step();
    step();
    chk("bubble_cnt_2", 32'(bubble_cnt_o), 32'd2);
    chk("stall_cnt_sat", 32'(stall_cnt_o), 32'd3);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
